time_entry: RTL

Front-panel time-entry controller for the egg timer. It debounces the five raw push-buttons and lets the user edit a four-digit MM:SS preset with a cursor. It issues the load/start controls to the countdown counter, and supplies the digits that the display driver shows while the timer is not running. It tracks the counter's `done` flag so that a finished run is acknowledged by the user and returns to editing.

---
 rtl/time_entry.sv | 108 ++++++++++
 1 files changed

// File: rtl/time_entry.sv
// time_entry: debounced front panel that edits an MM:SS preset and sequences load/start of the countdown
module time_entry #(
  parameter int DEBOUNCE_CYCLES = 1000000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_sel,
  input  logic       btn_inc,
  input  logic       btn_dec,
  input  logic       btn_start,
  input  logic       btn_clear,
  input  logic       done,
  output logic [3:0] a,
  output logic [3:0] b,
  output logic [3:0] c,
  output logic [3:0] d,
  output logic [1:0] cursor,
  output logic       load,
  output logic       str
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  typedef enum logic [1:0] {EDIT, LOAD, RUN, DONE} state_t;
  state_t state;
  logic [4:0] raw, s1, s2, lvl, prev, press;
  logic [CW-1:0] cnt [5];
  logic [3:0] dig [4];
  logic [3:0] cv, mx, up, dn;
  logic p_clr, p_start, p_sel, p_inc, p_dec, nz;
  assign raw = {btn_clear, btn_start, btn_sel, btn_inc, btn_dec};
  assign {a, b, c, d} = {dig[0], dig[1], dig[2], dig[3]};
  assign p_clr = press[4];
  assign p_start = press[3] & ~press[4];
  assign p_sel = press[2] & ~|press[4:3];
  assign p_inc = press[1] & ~|press[4:2];
  assign p_dec = press[0] & ~|press[4:1];
  assign nz = |{dig[0], dig[1], dig[2], dig[3]};
  assign cv = dig[cursor];
  assign mx = (cursor == 2'd1) ? 4'd5 : 4'd9;
  assign up = (cv == mx) ? 4'd0 : cv + 4'd1;
  assign dn = (cv == 4'd0) ? mx : cv - 4'd1;
  // Two-flop synchronizer and registered rising-edge detector on the accepted levels
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      s1 <= '0;
      s2 <= '0;
      prev <= '0;
      press <= '0;
    end else begin
      s1 <= raw;
      s2 <= s1;
      prev <= lvl;
      press <= lvl & ~prev;
    end
  // Debounce: a pending level change must persist DEBOUNCE_CYCLES cycles; reverting restarts the count
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      lvl <= '0;
      for (int i = 0; i < 5; i++) cnt[i] <= '0;
    end else begin
      for (int i = 0; i < 5; i++)
        if (s2[i] == lvl[i]) cnt[i] <= '0;
        else if (cnt[i] == CW'(DEBOUNCE_CYCLES - 1)) begin
          cnt[i] <= '0;
          lvl[i] <= s2[i];
        end else cnt[i] <= cnt[i] + 1'b1;
    end
  // Edit/run controller; digits, cursor, load and str are all registered here
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state <= EDIT;
      dig <= '{default: 4'd0};
      cursor <= 2'd0;
      load <= 1'b0;
      str <= 1'b0;
    end else begin
      load <= 1'b0;
      case (state)
        EDIT:
          if (p_clr) begin
            dig <= '{default: 4'd0};
            cursor <= 2'd0;
          end else if (p_start && nz) begin
            state <= LOAD;
            load <= 1'b1;
          end else if (p_sel) cursor <= cursor + 2'd1;
          else if (p_inc) dig[cursor] <= up;
          else if (p_dec) dig[cursor] <= dn;
        LOAD: begin
          state <= RUN;
          str <= 1'b1;
        end
        RUN:
          if (p_clr || p_start) begin
            state <= EDIT;
            str <= 1'b0;
          end else if (done) state <= DONE;
        DONE:
          if (|press) begin
            state <= EDIT;
            str <= 1'b0;
            if (p_clr) begin
              dig <= '{default: 4'd0};
              cursor <= 2'd0;
            end
          end
      endcase
    end
endmodule
